// File: rtl/game_timer_scheduler.sv
// game_timer_scheduler: 1 ms prescaler driving NUM_CH one-shot/periodic timeout channels with a priority event port
module game_timer_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int NUM_CH = 4,
  parameter int CNT_W = 8,
  parameter int CH_W = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_period,
  input  logic              cfg_periodic,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              event_ready,
  output logic              tick,
  output logic [NUM_CH-1:0] time_out,
  output logic [NUM_CH-1:0] busy,
  output logic              event_valid,
  output logic [CH_W-1:0]   event_ch,
  output logic [NUM_CH-1:0] overrun
);
  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  logic [PRE_W-1:0] pre;
  state_t state [NUM_CH];
  state_t state_n [NUM_CH];
  logic [CNT_W-1:0] rem [NUM_CH];
  logic [CNT_W-1:0] rem_n [NUM_CH];
  logic [CNT_W-1:0] period [NUM_CH];
  logic [NUM_CH-1:0] periodic, expire, pending, pend_n, consume;
  logic [CH_W-1:0] ch_n;
  // prescaler: tick is registered from the terminal count, so it lands the cycle after the wrap
  always_ff @(posedge clock) begin
    if (reset) begin
      pre <= '0;
      tick <= 1'b0;
    end else begin
      tick <= enable && pre == PRE_W'(TICK_DIV - 1);
      if (enable) pre <= (pre == PRE_W'(TICK_DIV - 1)) ? '0 : pre + 1'b1;
    end
  end
  // period/mode registers; only sampled on start or reload, never touching a running count
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) period[i] <= '0;
      periodic <= '0;
    end else if (cfg_we) begin
      period[cfg_ch] <= cfg_period;
      periodic[cfg_ch] <= cfg_periodic;
    end
  end
  // channel next-state: stop beats start beats tick; a zero period makes start a no-op
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_n[i] = state[i];
      rem_n[i] = rem[i];
      expire[i] = 1'b0;
      if (stop[i]) state_n[i] = IDLE;
      else if (start[i] && period[i] != '0) begin
        state_n[i] = RUN;
        rem_n[i] = period[i];
      end else if (state[i] == RUN && tick) begin
        if (rem[i] != CNT_W'(1)) rem_n[i] = rem[i] - 1'b1;
        else begin
          expire[i] = 1'b1;
          rem_n[i] = period[i];
          if (!periodic[i] || period[i] == '0) state_n[i] = IDLE;
        end
      end
    end
  end
  // pending set: a same-cycle expiry re-arms the bit being consumed
  always_comb begin
    consume = '0;
    if (event_valid && event_ready) consume[event_ch] = 1'b1;
    pend_n = (pending & ~consume) | expire;
    ch_n = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (pend_n[i]) ch_n = CH_W'(i);
  end
  // busy is a decode of the channel state register
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) busy[i] = state[i] == RUN;
  end
  // channel and event registers; overrun is sticky until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        rem[i] <= '0;
      end
      pending <= '0;
      time_out <= '0;
      overrun <= '0;
      event_valid <= 1'b0;
      event_ch <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state[i] <= state_n[i];
        rem[i] <= rem_n[i];
      end
      pending <= pend_n;
      time_out <= expire;
      overrun <= overrun | (expire & pending & ~consume);
      event_valid <= |pend_n;
      event_ch <= ch_n;
    end
  end
endmodule

// File: tb/tb_game_timer_scheduler.sv
// tb_game_timer_scheduler: random and directed stimulus checked against a cycle model of the timer scheduler
module tb_game_timer_scheduler;
  localparam int TD = 4, N = 4, W = 8, CW = 2;
  logic clock = 1'b0;
  logic reset, enable, cfg_we, cfg_periodic, event_ready;
  logic [CW-1:0] cfg_ch;
  logic [W-1:0] cfg_period;
  logic [N-1:0] start, stop;
  logic tick, event_valid;
  logic [N-1:0] time_out, busy, overrun;
  logic [CW-1:0] event_ch;
  int vectors = 0, miscompares = 0, cyc = 0;
  int m_pre, m_per[N], m_rem[N];
  bit m_tick;
  bit m_mode[N];
  bit [N-1:0] m_pend, m_ovr, m_to;
  int t0, t1, t2, t3, t4;
  game_timer_scheduler #(.TICK_DIV(TD), .NUM_CH(N), .CNT_W(W), .CH_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_periodic(cfg_periodic), .start(start), .stop(stop),
    .event_ready(event_ready), .tick(tick), .time_out(time_out), .busy(busy),
    .event_valid(event_valid), .event_ch(event_ch), .overrun(overrun)
  );
  always #5 clock = ~clock;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  function automatic int lowest(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction
  // reference: remaining ticks per channel, 0 meaning idle; pending kept as a bit set
  task automatic model_update();
    bit [N-1:0] cons, exp;
    bit old_tick;
    cons = '0;
    exp = '0;
    old_tick = m_tick;
    if (reset) begin
      m_pre = 0;
      m_tick = 0;
      for (int i = 0; i < N; i++) begin
        m_per[i] = 0;
        m_mode[i] = 0;
        m_rem[i] = 0;
      end
      m_pend = '0;
      m_ovr = '0;
      m_to = '0;
      return;
    end
    m_tick = enable && m_pre == TD - 1;
    if (enable) m_pre = (m_pre + 1) % TD;
    if (m_pend != 0 && event_ready) cons[lowest(m_pend)] = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (stop[i]) m_rem[i] = 0;
      else if (start[i] && m_per[i] != 0) m_rem[i] = m_per[i];
      else if (m_rem[i] != 0 && old_tick) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          exp[i] = 1'b1;
          if (m_mode[i]) m_rem[i] = m_per[i];
        end
      end
    end
    m_ovr |= exp & m_pend & ~cons;
    m_pend = (m_pend & ~cons) | exp;
    m_to = exp;
    if (cfg_we) begin
      m_per[cfg_ch] = int'(cfg_period);
      m_mode[cfg_ch] = cfg_periodic;
    end
  endtask
  task automatic step();
    bit [N-1:0] b;
    @(posedge clock);
    model_update();
    #1;
    for (int i = 0; i < N; i++) b[i] = m_rem[i] != 0;
    chk("tick", 32'(tick), 32'(m_tick));
    chk("time_out", 32'(time_out), 32'(m_to));
    chk("busy", 32'(busy), 32'(b));
    chk("event_valid", 32'(event_valid), 32'(m_pend != 0));
    chk("event_ch", 32'(event_ch), 32'(lowest(m_pend)));
    chk("overrun", 32'(overrun), 32'(m_ovr));
    cyc++;
  endtask
  task automatic cfg(int ch, int p, bit m);
    cfg_we = 1'b1;
    cfg_ch = CW'(ch);
    cfg_period = W'(p);
    cfg_periodic = m;
    step();
    cfg_we = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  task automatic pulse_start(logic [N-1:0] m);
    start = m;
    step();
    start = '0;
  endtask
  task automatic wait_pulse(output int t);
    t = -1000;
    for (int k = 0; k < 100; k++) begin
      step();
      if (time_out[1]) begin
        t = cyc;
        return;
      end
    end
  endtask
  initial begin
    reset = 1'b1; enable = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_periodic = 1'b0;
    start = '0; stop = '0; event_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    cfg(0, 3, 0);
    repeat (6) step();
    pulse_start(4'b0001);
    repeat (20) step();
    do_reset();
    cfg(1, 2, 1);
    pulse_start(4'b0010);
    wait_pulse(t0);
    wait_pulse(t1);
    chk("periodic_gap_p2", 32'(t1 - t0), 32'd8);
    cfg(1, 5, 1);
    wait_pulse(t2);
    wait_pulse(t3);
    wait_pulse(t4);
    chk("gap_after_write", 32'(t2 - t1), 32'd8);
    chk("gap_p5_a", 32'(t3 - t2), 32'd20);
    chk("gap_p5_b", 32'(t4 - t3), 32'd20);
    event_ready = 1'b1;
    repeat (4) step();
    do_reset();
    cfg(2, 3, 0);
    pulse_start(4'b0100);
    for (int k = 0; k < 50 && !(m_tick && m_rem[2] == 1); k++) step();
    stop = 4'b0100;
    step();
    stop = '0;
    chk("stop_race_busy", 32'(busy[2]), 32'd0);
    repeat (10) step();
    start = 4'b0100;
    stop = 4'b0100;
    step();
    start = '0;
    stop = '0;
    chk("start_stop_idle", 32'(busy[2]), 32'd0);
    repeat (3) step();
    event_ready = 1'b0;
    do_reset();
    cfg(0, 2, 0);
    cfg(3, 2, 0);
    pulse_start(4'b1001);
    repeat (14) step();
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
    step();
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
    repeat (2) step();
    do_reset();
    cfg(1, 1, 1);
    pulse_start(4'b0010);
    repeat (20) step();
    event_ready = 1'b1;
    repeat (10) step();
    do_reset();
    cfg(0, 3, 0);
    pulse_start(4'b0001);
    repeat (5) step();
    enable = 1'b0;
    repeat (7) step();
    enable = 1'b1;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    pulse_start(4'b1111);
    repeat (10) step();
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 299) == 0;
      enable = $urandom_range(0, 9) != 0;
      cfg_we = $urandom_range(0, 7) == 0;
      cfg_ch = CW'($urandom_range(0, N - 1));
      cfg_period = W'($urandom_range(0, 4));
      cfg_periodic = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        start[i] = $urandom_range(0, 19) == 0;
        stop[i] = $urandom_range(0, 39) == 0;
      end
      event_ready = $urandom_range(0, 2) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
